// File: rtl/score_timer_bcd_pkg.sv
// Shared types, constants and BCD helpers for the whack-a-mole score/timer block.
package score_timer_bcd_pkg;

  // Game sequencing states; 2'b11 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_OVER = 2'b10
  } state_e;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [3:0] BCD_MIN_DIGIT = 4'd0;

  // Two-digit BCD value, tens in the upper nibble.
  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  localparam bcd2_t BCD2_ZERO = '{tens: 4'd0, ones: 4'd0};
  localparam bcd2_t BCD2_ONE  = '{tens: 4'd0, ones: 4'd1};
  localparam bcd2_t BCD2_MAX  = '{tens: 4'd9, ones: 4'd9};

  // Convert a seconds count (1..99) to a BCD pair at elaboration time.
  function automatic bcd2_t secs_to_bcd2(input int unsigned secs);
    bcd2_t       r;
    int unsigned t;
    int unsigned o;
    t      = (secs / 32'd10) % 32'd10;
    o      = secs % 32'd10;
    r.tens = t[3:0];
    r.ones = o[3:0];
    return r;
  endfunction

  // True when both nibbles hold a legal decimal digit.
  function automatic logic bcd2_is_valid(input bcd2_t v);
    return (v.tens <= BCD_MAX_DIGIT) && (v.ones <= BCD_MAX_DIGIT);
  endfunction

  // BCD increment that holds at 99; ones wrap 9 -> 0 carrying into tens.
  function automatic bcd2_t bcd2_inc_sat(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v == BCD2_MAX) begin
      r = BCD2_MAX;
    end else if (v.ones == BCD_MAX_DIGIT) begin
      r.ones = BCD_MIN_DIGIT;
      r.tens = v.tens + 4'd1;
    end else begin
      r.ones = v.ones + 4'd1;
    end
    return r;
  endfunction

  // BCD decrement that holds at 00; ones wrap 0 -> 9 borrowing from tens.
  function automatic bcd2_t bcd2_dec_floor(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v == BCD2_ZERO) begin
      r = BCD2_ZERO;
    end else if (v.ones == BCD_MIN_DIGIT) begin
      r.ones = BCD_MAX_DIGIT;
      r.tens = v.tens - 4'd1;
    end else begin
      r.ones = v.ones - 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/score_timer_bcd_counter.sv
// Two-digit BCD counter: clear, load, saturating increment, floored decrement.
// Used once as the countdown timer and once as the hit score.
module bcd2_counter
  import score_timer_bcd_pkg::*;
#(
  parameter bcd2_t RESET_VAL = BCD2_ZERO
) (
  input  logic       master_clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  bcd2_t value_q;
  bcd2_t value_d;
  bcd2_t load_val_s;

  assign load_val_s = '{tens: load_tens, ones: load_ones};

  // Next value: clear beats load beats counting; inc and dec together cancel.
  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = BCD2_ZERO;
    end else if (load) begin
      value_d = load_val_s;
    end else if (!bcd2_is_valid(value_q)) begin
      value_d = RESET_VAL;
    end else if (inc && !dec) begin
      value_d = bcd2_inc_sat(value_q);
    end else if (dec && !inc) begin
      value_d = bcd2_dec_floor(value_q);
    end else begin
      value_d = value_q;
    end
  end

  // Counter register, asynchronously forced to its reset value.
  always_ff @(posedge master_clk or negedge rst) begin
    if (!rst) begin
      value_q <= RESET_VAL;
    end else begin
      value_q <= value_d;
    end
  end

  assign tens = value_q.tens;
  assign ones = value_q.ones;

endmodule

// File: rtl/score_timer_bcd.sv
// Whack-a-mole game state: BCD countdown (digits 1-2) and BCD score (digits 3-4),
// sequenced IDLE -> RUN -> OVER. All outputs come straight from flops.
module score_timer_bcd
  import score_timer_bcd_pkg::*;
#(
  parameter int unsigned GAME_SECONDS = 60
) (
  input  logic       master_clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       start,
  input  logic       hit,
  output logic [3:0] digit_1,
  output logic [3:0] digit_2,
  output logic [3:0] digit_3,
  output logic [3:0] digit_4,
  output logic       running,
  output logic       game_over
);

  localparam bcd2_t GAME_BCD = secs_to_bcd2(GAME_SECONDS);

  state_e     state_q;
  state_e     state_d;
  logic       running_q;
  logic       running_d;
  logic       game_over_q;
  logic       game_over_d;

  logic       start_game_s;
  logic       time_dec_s;
  logic       score_inc_s;
  logic [3:0] time_tens_s;
  logic [3:0] time_ones_s;
  logic [3:0] score_tens_s;
  logic [3:0] score_ones_s;
  bcd2_t      time_val_s;

  assign time_val_s = '{tens: time_tens_s, ones: time_ones_s};

  // Next-state and counter control decode; start is only honoured outside RUN.
  always_comb begin
    state_d      = state_q;
    start_game_s = 1'b0;
    time_dec_s   = 1'b0;
    score_inc_s  = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          start_game_s = 1'b1;
          state_d      = ST_RUN;
        end else begin
          state_d      = state_q;
        end
      end
      ST_RUN: begin
        time_dec_s  = tick_1hz;
        score_inc_s = hit;
        if (tick_1hz && (time_val_s == BCD2_ONE)) begin
          state_d = ST_OVER;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    running_d   = (state_d == ST_RUN);
    game_over_d = (state_d == ST_OVER);
  end

  // State and status flags registered together so they change on the same edge.
  always_ff @(posedge master_clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      running_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      running_q   <= running_d;
      game_over_q <= game_over_d;
    end
  end

  bcd2_counter #(
    .RESET_VAL (GAME_BCD)
  ) u_timer (
    .master_clk (master_clk),
    .rst        (rst),
    .clr        (1'b0),
    .load       (start_game_s),
    .load_tens  (GAME_BCD.tens),
    .load_ones  (GAME_BCD.ones),
    .inc        (1'b0),
    .dec        (time_dec_s),
    .tens       (time_tens_s),
    .ones       (time_ones_s)
  );

  bcd2_counter #(
    .RESET_VAL (BCD2_ZERO)
  ) u_score (
    .master_clk (master_clk),
    .rst        (rst),
    .clr        (start_game_s),
    .load       (1'b0),
    .load_tens  (4'd0),
    .load_ones  (4'd0),
    .inc        (score_inc_s),
    .dec        (1'b0),
    .tens       (score_tens_s),
    .ones       (score_ones_s)
  );

  assign digit_1   = time_tens_s;
  assign digit_2   = time_ones_s;
  assign digit_3   = score_tens_s;
  assign digit_4   = score_ones_s;
  assign running   = running_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_score_timer_bcd.sv
// Scoreboard bench: three instances (5, 60, 99 s) driven from one clock.
// An integer game model predicts each cycle; expected vectors are queued at
// drive time and compared one cycle later.
module tb_score_timer_bcd;

  localparam int NI = 3;
  localparam int GS_TAB [NI] = '{5, 60, 99};

  logic master_clk = 1'b0;
  logic rst;
  logic [NI-1:0] start_v;
  logic [NI-1:0] tick_v;
  logic [NI-1:0] hit_v;
  logic [NI-1:0][3:0] d1;
  logic [NI-1:0][3:0] d2;
  logic [NI-1:0][3:0] d3;
  logic [NI-1:0][3:0] d4;
  logic [NI-1:0] running_o;
  logic [NI-1:0] over_o;

  int n_checks = 0;
  int n_errors = 0;

  // model state: 0 idle, 1 run, 2 over
  int m_st    [NI];
  int m_time  [NI];
  int m_score [NI];

  typedef struct {
    int          inst;
    logic [17:0] exp;
  } sb_t;
  sb_t sb_q[$];

  always #5 master_clk = ~master_clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    if (GS_TAB[g] < 1 || GS_TAB[g] > 99) begin : g_bad
      initial $fatal(1, "FAIL gs_range: GAME_SECONDS=%0d required 1..99", GS_TAB[g]);
    end
    score_timer_bcd #(.GAME_SECONDS(GS_TAB[g])) u_dut (
      .master_clk (master_clk),
      .rst        (rst),
      .tick_1hz   (tick_v[g]),
      .start      (start_v[g]),
      .hit        (hit_v[g]),
      .digit_1    (d1[g]),
      .digit_2    (d2[g]),
      .digit_3    (d3[g]),
      .digit_4    (d4[g]),
      .running    (running_o[g]),
      .game_over  (over_o[g])
    );
  end

  task automatic check_val(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got t=%h%h s=%h%h run=%b over=%b, expected t=%h%h s=%h%h run=%b over=%b",
               tag, obs[17:14], obs[13:10], obs[9:6], obs[5:2], obs[1], obs[0],
               exp[17:14], exp[13:10], exp[9:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [17:0] model_vec(input int i);
    logic [3:0] tt, to, st, so;
    tt = 4'(m_time[i] / 10);
    to = 4'(m_time[i] % 10);
    st = 4'(m_score[i] / 10);
    so = 4'(m_score[i] % 10);
    return {tt, to, st, so, (m_st[i] == 1), (m_st[i] == 2)};
  endfunction

  function automatic logic [17:0] dut_vec(input int i);
    return {d1[i], d2[i], d3[i], d4[i], running_o[i], over_o[i]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_st[k]    = 0;
      m_time[k]  = GS_TAB[k];
      m_score[k] = 0;
    end
  endtask

  task automatic model_step(input int i, input bit s, input bit t, input bit h);
    if (m_st[i] == 1) begin
      if (h && m_score[i] < 99) m_score[i] = m_score[i] + 1;
      if (t) begin
        m_time[i] = m_time[i] - 1;
        if (m_time[i] == 0) m_st[i] = 2;
      end
    end else if (s) begin
      m_st[i]    = 1;
      m_time[i]  = GS_TAB[i];
      m_score[i] = 0;
    end
  endtask

  task automatic drain(input string tag);
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val($sformatf("%s[%0d]", tag, e.inst), dut_vec(e.inst), e.exp);
    end
  endtask

  task automatic cyc(input string tag, input int i, input bit s, input bit t, input bit h);
    sb_t e;
    @(negedge master_clk);
    start_v[i] = s;
    tick_v[i]  = t;
    hit_v[i]   = h;
    for (int k = 0; k < NI; k++) begin
      model_step(k, start_v[k], tick_v[k], hit_v[k]);
      e.inst = k;
      e.exp  = model_vec(k);
      sb_q.push_back(e);
    end
    @(posedge master_clk);
    #1;
    start_v = '0;
    tick_v  = '0;
    hit_v   = '0;
    drain(tag);
  endtask

  // Assert reset between edges and compare before any further clock edge.
  task automatic async_reset(input string tag);
    sb_t e;
    @(posedge master_clk);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < NI; k++) begin
      e.inst = k;
      e.exp  = model_vec(k);
      sb_q.push_back(e);
    end
    drain(tag);
    @(negedge master_clk);
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected bench to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sb_t e;
    start_v = '0;
    tick_v  = '0;
    hit_v   = '0;
    rst     = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < NI; k++) begin
      e.inst = k;
      e.exp  = model_vec(k);
      sb_q.push_back(e);
    end
    drain("por");
    @(negedge master_clk);
    rst = 1'b1;

    // 5 s game: start, 3 ticks, 12 hits
    cyc("start5", 0, 1'b1, 1'b0, 1'b0);
    repeat (3) cyc("tick5", 0, 1'b0, 1'b1, 1'b0);
    repeat (12) cyc("hit5", 0, 1'b0, 1'b0, 1'b1);
    cyc("start_in_run", 0, 1'b1, 1'b0, 1'b0);
    cyc("tick_to_01", 0, 1'b0, 1'b1, 1'b0);
    cyc("final_tick_hit", 0, 1'b0, 1'b1, 1'b1);
    cyc("over_hit", 0, 1'b0, 1'b0, 1'b1);
    cyc("over_tick", 0, 1'b0, 1'b1, 1'b0);
    cyc("restart_over", 0, 1'b1, 1'b0, 1'b0);
    repeat (4) cyc("tick5b", 0, 1'b0, 1'b1, 1'b0);
    cyc("final_tick_hit_b", 0, 1'b0, 1'b1, 1'b1);
    cyc("over_start_tick", 0, 1'b1, 1'b1, 1'b1);

    // 60 s game: borrow on first tick, carry on tenth hit
    cyc("start60", 1, 1'b1, 1'b0, 1'b0);
    cyc("borrow60", 1, 1'b0, 1'b1, 1'b0);
    repeat (9) cyc("hit60", 1, 1'b0, 1'b0, 1'b1);
    cyc("carry60", 1, 1'b0, 1'b0, 1'b1);
    cyc("tick_hit60", 1, 1'b0, 1'b1, 1'b1);
    cyc("idle_ignore", 2, 1'b0, 1'b1, 1'b1);

    // abort running games
    async_reset("mid_run_reset");

    // 99 s game: start with hit in IDLE, then saturate score
    cyc("start_hit_idle", 2, 1'b1, 1'b0, 1'b1);
    repeat (105) cyc("hit99", 2, 1'b0, 1'b0, 1'b1);
    cyc("tick99", 2, 1'b0, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
